// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the program loader. This
//                covers the loader state encoding and the instruction-memory
//                word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs little-endian bytes into a 32-bit word. The first byte
//                received lands in bits [7:0]. word_ready_o pulses
//                combinationally with the fourth accepted byte of each word.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Shift each new byte in from the top so the earliest byte ends up lowest.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            word_d = '0;
        end else if (byte_valid_i) begin
            word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // Byte counter and shift register storage.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Receives a byte-serial program image (16-bit LE word count,
//                then LE data words). It writes the words into instruction
//                memory from word 0 and holds the CPU in reset until the
//                image is complete and valid.
//                Optional macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR
//                checksum byte that must match all data bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_DEPTH = 1024,
    parameter int AW       = 10
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              im_we_o,
    output logic [AW-1:0]     im_addr_o,
    output logic [WORD_W-1:0] im_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [16:0] C_DEPTH = 17'(IM_DEPTH);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t C_TAIL_ST = ST_CSUM;
`else
    localparam state_t C_TAIL_ST = ST_DONE;
`endif

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [15:0]       remain_q, remain_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic              asm_clear;
    logic              asm_valid;
    logic              asm_ready;
    logic [15:0]       w_len;

    assign w_len     = {rx_data_i, len_lo_q};
    assign asm_valid = (state_q == ST_DATA) && rx_valid_i;

    word_assembler u_asm (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data_i),
        .word_o       (im_wdata_o),
        .word_ready_o (asm_ready)
    );

    // Next-state logic and Moore/Mealy outputs of the load sequencer.
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        err_d      = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        asm_clear  = 1'b0;
        rx_ready_o = 1'b0;
        im_we_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        cpu_hold_o = 1'b1;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    done_o     = 1'b1;
                    cpu_hold_o = err_q;
                end
                if (start_i) begin
                    // Restart from DONE grabs the CPU again immediately.
                    cpu_hold_o = 1'b1;
                    state_d    = ST_LEN_LO;
                    err_d      = 1'b0;
                    addr_d     = '0;
                    asm_clear  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i) begin
                    remain_d = w_len;
                    if (w_len == 16'd0) begin
                        state_d = C_TAIL_ST;
                    end else if ({1'b0, w_len} > C_DEPTH) begin
                        // Oversized image is rejected before touching memory.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data_i;
`endif
                    if (asm_ready) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                busy_o   = 1'b1;
                im_we_o  = 1'b1;
                addr_d   = addr_q + AW'(1);
                remain_d = remain_q - 16'd1;
                state_d  = (remain_q == 16'd1) ? C_TAIL_ST : ST_DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (rx_valid_i) begin
                    if (rx_data_i != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            remain_q <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign im_addr_o = addr_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Scoreboard bench for prog_loader. Expected memory writes are
//                queued as stimulus is issued, and a monitor compares every
//                im_we pulse against them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        im_we;
    logic [AW-1:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wcount = 0;
    logic [41:0] sb[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    prog_loader #(.IM_DEPTH(1024), .AW(AW)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            wcount++;
            if (sb.size() == 0) begin
                check("unexpected_im_we", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                logic [41:0] e;
                e = sb.pop_front();
                check("im_addr", 32'(im_addr), 32'(e[41:32]));
                check("im_wdata", im_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        forever begin
            if (rx_ready) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            t++;
            if (t > 50) begin
                check("rx_ready_timeout", 32'd0, 32'd1);
                rx_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_img(input bit gap);
        foreach (img[i]) begin
            send_byte(img[i]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        check("cpu_hold_on_start", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_two_words(input bit gap);
        wcount = 0;
        sb.push_back({10'd0, 32'h1234_5678});
        sb.push_back({10'd1, 32'hDEAD_BEEF});
        pulse_start();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(8'h2A);
`endif
        send_img(gap);
        wait_done();
        @(negedge clk);
        check("n2_done", 32'(done), 32'd1);
        check("n2_err", 32'(err), 32'd0);
        check("n2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("n2_busy", 32'(busy), 32'd0);
        check("n2_addr_end", 32'(im_addr), 32'd2);
        check("n2_write_count", 32'(wcount), 32'd2);
        check("n2_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset values while reset is held.
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_im_we", 32'(im_we), 32'd0);
        check("idle_im_addr", 32'(im_addr), 32'd0);
        check("idle_im_wdata", im_wdata, 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        // Back-to-back and throttled loads of the same image.
        load_two_words(1'b0);
        load_two_words(1'b1);

        // Oversized length: rejected with no writes.
        wcount = 0;
        pulse_start();
        img = '{8'h01, 8'h04};
        send_img(1'b0);
        wait_done();
        @(negedge clk);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_cpu_hold", 32'(cpu_hold), 32'd1);
        check("ovf_write_count", 32'(wcount), 32'd0);

        // Empty image completes cleanly and clears the previous error.
        pulse_start();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_err_clr", 32'(err), 32'd0);
        img = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(8'h00);
`endif
        send_img(1'b0);
        wait_done();
        @(negedge clk);
        check("n0_done", 32'(done), 32'd1);
        check("n0_err", 32'(err), 32'd0);
        check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
        check("n0_addr", 32'(im_addr), 32'd0);

        // Reset mid-load after five data bytes.
        wcount = 0;
        sb.push_back({10'd0, 32'h1234_5678});
        pulse_start();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        send_img(1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_addr", 32'(im_addr), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_writes", 32'(wcount), 32'd1);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_two_words(1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum accepted, then checksum rejected.
        sb.push_back({10'd0, 32'h0403_0201});
        pulse_start();
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_img(1'b0);
        wait_done();
        @(negedge clk);
        check("csum_ok_err", 32'(err), 32'd0);
        check("csum_ok_hold", 32'(cpu_hold), 32'd0);
        sb.push_back({10'd0, 32'h0403_0201});
        pulse_start();
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_img(1'b0);
        wait_done();
        @(negedge clk);
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_hold", 32'(cpu_hold), 32'd1);
        check("csum_sb_empty", 32'(sb.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
